uart_rx_os: RTL and testbench
=============================

Name: uart_rx_os

Overview:
Oversampling UART receiver: the receive end of the 8N1 serial link driven by the team's UART transmitter.
- Samples the asynchronous `rx` line at 16x the baud rate.
- Validates start and stop bits, deserialises LSB-first data, and presents each byte with a one-cycle ready strobe.
- Sits between the board RX pin and the command/data consumer logic; standalone, so the link can be tested by looping `tx` into it.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- BAUD, 9600, line bit rate in baud.
- OVERSAMPLE, 16, sample ticks per bit; must be even, >= 8.
- N, 7, MSB index of the data word (word width N+1).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- rx  input  1  serial line, idle high, asynchronous to clk.
- data_out  output  N+1  last correctly framed byte received.
- rx_data_rdy  output  1  one-clk pulse: data_out updated this cycle.
- frame_err  output  1  one-clk pulse: stop bit sampled low.
- busy  output  1  high from start-bit detection until return to IDLE.

Behaviour:
- Reset values (while reset=0): data_out=0, rx_data_rdy=0, frame_err=0, busy=0, FSM=IDLE, counters=0, synchroniser flops=1.
- Synchronisation: rx passes through 2 flops (rx_s). All decisions use rx_s; 2-clk input latency.
- Tick generator:
  - DIV = CLK_FREQ/(BAUD*OVERSAMPLE), integer floor (651 at defaults).
  - Emits a 1-clk `tick` every DIV clocks.
  - Restarted (count=0) on the IDLE->START transition so sampling is aligned to the start edge.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
- IDLE: rx_s falling (1->0) -> START, busy=1, sample counter sc=0.
- START: count ticks. Majority of samples at ticks OVERSAMPLE/2-1, /2, /2+1 (7, 8, 9).
  - Majority 0 -> DATA with bit index bi=0 and sc=0.
  - Majority 1 -> false start, return to IDLE, busy=0, no strobes.
- DATA: each bit spans OVERSAMPLE ticks, sampled by the same 3-sample majority at mid-bit.
  - Shift register fills LSB first.
  - After bit N is sampled and the bit period completes -> STOP.
- STOP: majority sample at mid-stop-bit.
  - 1 -> data_out <= shift register, rx_data_rdy=1 for exactly one clk, -> IDLE at once (mid-stop), busy=0.
  - 0 -> frame_err=1 for one clk, data_out unchanged, -> WAIT_IDLE.
- WAIT_IDLE: stay until rx_s=1 for a full OVERSAMPLE ticks, then -> IDLE, busy=0. This prevents a break condition from being read as 0x00 frames.
- Latency: rx_data_rdy rises about 9.5 bit times after the start edge, plus 2 clks synchroniser, plus at most 1 clk.
- Back-to-back frames: returning to IDLE at mid-stop leaves a half-bit margin, so a start edge immediately after the stop bit must be caught.
- rx_data_rdy and frame_err are mutually exclusive and never both high.
- Reset asserted mid-frame: immediate return to reset values; the partial byte is discarded, with no strobes on release.
- Glitch on idle line shorter than about OVERSAMPLE/2 ticks: rejected as a false start.

Decomposition:
- Package uart_pkg:
  - state enum typedef (IDLE/START/DATA/STOP/WAIT_IDLE);
  - default CLK_FREQ/BAUD/OVERSAMPLE constants;
  - function computing DIV.
- Sub-module uart_baud_tick: parameterised divisor counter with sync restart input and 1-clk tick output. It is reusable by the transmitter side.
- Synchroniser, majority vote and FSM stay in uart_rx_os.

Test Plan:
1. Hold reset=0 for 30 clks with rx toggling -> all outputs 0, busy=0. After release with rx=1 idle for 1 bit time -> no strobes.
2. Drive frame 0x9D at 9600 baud (bits 1,0,1,1,1,0,0,1 LSB first, stop=1) -> exactly one rx_data_rdy pulse, data_out=8'h9D, frame_err never high, busy falls with the strobe.
3. Back-to-back 0x55 then 0xAA with no idle gap -> two rx_data_rdy pulses about 10 bit times apart, data_out=8'h55 then 8'hAA.
4. Frame 0xF0 with stop bit forced 0, then line held low 3 bit times, then high -> one frame_err pulse, no rx_data_rdy, data_out keeps previous value. busy stays 1 until 1 bit time after rx returns high.
5. 3-tick (about 0.2 bit) low glitch on idle line -> no strobes, busy back to 0 before tick 10. A valid 0x00 frame afterwards -> data_out=8'h00, one rx_data_rdy.
6. Assert reset for 5 clks during data bit 4 of frame 0x3C, release, then send 0xA5 -> no strobe for the aborted frame, data_out=8'hA5 with one rx_data_rdy.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the 8N1 UART blocks: receiver state encoding,
// default link constants and the baud-tick divisor helper.
package uart_pkg;

  localparam int DEF_CLK_FREQ  = 100_000_000;
  localparam int DEF_BAUD      = 9600;
  localparam int DEF_OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } rx_state_e;

  // Clocks per oversample tick, floored; never below 1 so the tick
  // generator degenerates to "every clock" rather than to no tick at all.
  function automatic int calc_div(input int clk_freq, input int baud, input int os);
    int d;
    d = clk_freq / (baud * os);
    if (d < 1) d = 1;
    return d;
  endfunction

  // Two-out-of-three vote used for the mid-bit samples.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-clock o_tick every DIV clocks. i_restart
// zeroes the count so the following ticks are phase-aligned to the event
// that caused the restart (start edge on RX, start of frame on TX).
module uart_baud_tick #(
  parameter int DIV = 651
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_restart,
  output logic o_tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] TC = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  // Divisor counter: wraps at terminal count, restarts on request.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_restart || (r_cnt == TC)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tick = (r_cnt == TC) && !i_restart;

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling 8N1 UART receiver.
//
//   state     | meaning
//   ----------+----------------------------------------------------------
//   IDLE      | line idle, waiting for a falling edge on the synced input
//   START     | qualifying the start bit by mid-bit majority, then
//             | finishing the start-bit period
//   DATA      | sampling N+1 data bits LSB first, one per bit period
//   STOP      | mid-stop-bit vote: good frame -> strobe data, else error
//   WAIT_IDLE | after a framing error, wait for a full bit of idle high
//
// Sample ticks inside a bit are numbered 0..OVERSAMPLE-1 by r_sc; the vote
// uses ticks OVERSAMPLE/2-1, /2 and /2+1. The START state keeps counting to
// the end of the start bit so that DATA sees whole bit periods.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = DEF_CLK_FREQ,
  parameter int BAUD       = DEF_BAUD,
  parameter int OVERSAMPLE = DEF_OVERSAMPLE,
  parameter int N          = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [N:0] data_out,
  output logic       rx_data_rdy,
  output logic       frame_err,
  output logic       busy
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int SCW = $clog2(OVERSAMPLE);
  localparam int BIW = (N > 0) ? $clog2(N + 1) : 1;

  localparam logic [SCW-1:0] SC_LAST = SCW'(OVERSAMPLE - 1);
  localparam logic [SCW-1:0] SC_S0   = SCW'(OVERSAMPLE / 2 - 1);
  localparam logic [SCW-1:0] SC_S1   = SCW'(OVERSAMPLE / 2);
  localparam logic [SCW-1:0] SC_S2   = SCW'(OVERSAMPLE / 2 + 1);
  localparam logic [BIW-1:0] BI_LAST = BIW'(N);

  logic r_sync1;
  logic r_rx_s;
  logic r_rx_d;

  rx_state_e      r_state;
  logic [SCW-1:0] r_sc;
  logic [BIW-1:0] r_bi;
  logic [N:0]     r_shift;
  logic           r_v0;
  logic           r_v1;
  logic [N:0]     r_data_out;
  logic           r_rdy;
  logic           r_ferr;
  logic           r_busy;

  logic w_fall;
  logic w_restart;
  logic w_tick;
  logic w_vote;

  // Two-flop synchroniser plus a delayed copy for edge detection; all
  // reset high so releasing reset on an idle line never looks like a start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b1;
      r_rx_s  <= 1'b1;
      r_rx_d  <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_rx_s  <= r_sync1;
      r_rx_d  <= r_rx_s;
    end
  end

  assign w_fall    = r_rx_d & ~r_rx_s;
  assign w_restart = (r_state == IDLE) && w_fall;
  // Third vote is the live sample taken on the last of the three ticks.
  assign w_vote    = maj3(r_v0, r_v1, r_rx_s);

  uart_baud_tick #(
    .DIV (DIV)
  ) u_tick (
    .i_clk     (clk),
    .i_rst_n   (reset),
    .i_restart (w_restart),
    .o_tick    (w_tick)
  );

  // Receive FSM with registered strobes, busy flag and output byte.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_sc       <= '0;
      r_bi       <= '0;
      r_shift    <= '0;
      r_v0       <= 1'b0;
      r_v1       <= 1'b0;
      r_data_out <= '0;
      r_rdy      <= 1'b0;
      r_ferr     <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_rdy  <= 1'b0;
      r_ferr <= 1'b0;

      if (w_tick) begin
        if (r_sc == SC_S0) r_v0 <= r_rx_s;
        if (r_sc == SC_S1) r_v1 <= r_rx_s;
      end

      case (r_state)
        IDLE: begin
          if (w_fall) begin
            r_state <= START;
            r_sc    <= '0;
            r_busy  <= 1'b1;
          end
        end

        START: begin
          if (w_tick) begin
            if ((r_sc == SC_S2) && w_vote) begin
              // Line was high again at mid-bit: glitch, not a start bit.
              r_state <= IDLE;
              r_sc    <= '0;
              r_busy  <= 1'b0;
            end else if (r_sc == SC_LAST) begin
              r_state <= DATA;
              r_sc    <= '0;
              r_bi    <= '0;
            end else begin
              r_sc <= r_sc + 1'b1;
            end
          end
        end

        DATA: begin
          if (w_tick) begin
            if (r_sc == SC_S2) r_shift <= {w_vote, r_shift[N:1]};
            if (r_sc == SC_LAST) begin
              r_sc <= '0;
              if (r_bi == BI_LAST) begin
                r_state <= STOP;
              end else begin
                r_bi <= r_bi + 1'b1;
              end
            end else begin
              r_sc <= r_sc + 1'b1;
            end
          end
        end

        STOP: begin
          if (w_tick) begin
            if (r_sc == SC_S2) begin
              r_sc <= '0;
              if (w_vote) begin
                // Leave at mid-stop so a start edge right after the stop
                // bit still finds us in IDLE.
                r_data_out <= r_shift;
                r_rdy      <= 1'b1;
                r_busy     <= 1'b0;
                r_state    <= IDLE;
              end else begin
                r_ferr  <= 1'b1;
                r_state <= WAIT_IDLE;
              end
            end else begin
              r_sc <= r_sc + 1'b1;
            end
          end
        end

        WAIT_IDLE: begin
          // Any low sample restarts the idle count, so a held break is
          // never reinterpreted as a stream of zero bytes.
          if (!r_rx_s) begin
            r_sc <= '0;
          end else if (w_tick) begin
            if (r_sc == SC_LAST) begin
              r_sc    <= '0;
              r_busy  <= 1'b0;
              r_state <= IDLE;
            end else begin
              r_sc <= r_sc + 1'b1;
            end
          end
        end

        default: begin
          r_state <= IDLE;
          r_sc    <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign data_out    = r_data_out;
  assign rx_data_rdy = r_rdy;
  assign frame_err   = r_ferr;
  assign busy        = r_busy;

endmodule

// File: tb/tb_uart_rx_os.sv
// Scoreboard bench for uart_rx_os. The clock is scaled so that one
// oversample tick is 4 clocks (64 clocks per bit at 9600 baud).
module tb_uart_rx_os;

  localparam int TB_CLK_FREQ = 614_400;
  localparam int TB_BAUD     = 9600;
  localparam int TB_OS       = 16;
  localparam int BIT_CLKS    = (TB_CLK_FREQ / (TB_BAUD * TB_OS)) * TB_OS;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
  } exp_t;

  logic       clk;
  logic       reset;
  logic       rx;
  logic [7:0] data_out;
  logic       rx_data_rdy;
  logic       frame_err;
  logic       busy;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  exp_t q[$];
  int   rdy_cycles[$];
  logic [7:0] last_good = 8'h00;

  uart_rx_os #(
    .CLK_FREQ   (TB_CLK_FREQ),
    .BAUD       (TB_BAUD),
    .OVERSAMPLE (TB_OS),
    .N          (7)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx          (rx),
    .data_out    (data_out),
    .rx_data_rdy (rx_data_rdy),
    .frame_err   (frame_err),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_byte(input logic [7:0] d);
    exp_t e;
    e.is_err = 1'b0;
    e.data   = d;
    q.push_back(e);
    last_good = d;
  endtask

  task automatic expect_err();
    exp_t e;
    e.is_err = 1'b1;
    e.data   = last_good;
    q.push_back(e);
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_v);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop_v);
  endtask

  // Monitor: every strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    cyc = cyc + 1;
    if (rx_data_rdy || frame_err) begin
      chk("strobe_exclusive", {31'd0, rx_data_rdy & frame_err}, 32'd0);
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_strobe: rdy=%0b ferr=%0b data_out=%0h, expected no strobe (cycle %0d)",
                 rx_data_rdy, frame_err, data_out, cyc);
      end else begin
        e = q.pop_front();
        chk("strobe_kind_ferr", {31'd0, frame_err}, {31'd0, e.is_err});
        chk("data_out", {24'd0, data_out}, {24'd0, e.data});
        chk("busy_at_strobe", {31'd0, busy}, {31'd0, e.is_err});
        if (rx_data_rdy) rdy_cycles.push_back(cyc);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d expected completion", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    int t_edge;
    int d;

    reset = 1'b0;
    rx    = 1'b1;

    // 1: reset held with rx toggling
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      rx = i[0];
      if ((i % 10) == 9) begin
        chk("rst_data_out", {24'd0, data_out}, 32'd0);
        chk("rst_rdy", {31'd0, rx_data_rdy}, 32'd0);
        chk("rst_ferr", {31'd0, frame_err}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
      end
    end
    rx = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    drive_bit(1'b1);
    chk("idle_busy", {31'd0, busy}, 32'd0);

    // 2: single frame 0x9D
    base   = rdy_cycles.size();
    t_edge = cyc;
    expect_byte(8'h9D);
    send_frame(8'h9D, 1'b1);
    drive_bit(1'b1);
    if (rdy_cycles.size() > base) begin
      d = rdy_cycles[base] - t_edge;
      chk("latency_in_range", {31'd0, (d >= 9 * BIT_CLKS) && (d <= 10 * BIT_CLKS)}, 32'd1);
    end else begin
      chk("frame_9D_strobe_count", rdy_cycles.size() - base, 32'd1);
    end

    // 3: back-to-back 0x55, 0xAA
    base = rdy_cycles.size();
    expect_byte(8'h55);
    send_frame(8'h55, 1'b1);
    expect_byte(8'hAA);
    send_frame(8'hAA, 1'b1);
    drive_bit(1'b1);
    chk("b2b_strobe_count", rdy_cycles.size() - base, 32'd2);
    if (rdy_cycles.size() - base == 2) begin
      d = rdy_cycles[base + 1] - rdy_cycles[base];
      chk("b2b_spacing", {31'd0, (d >= 10 * BIT_CLKS - 10) && (d <= 10 * BIT_CLKS + 10)}, 32'd1);
    end

    // 4: framing error, then break, then idle
    expect_err();
    send_frame(8'hF0, 1'b0);
    repeat (3) drive_bit(1'b0);
    chk("break_busy", {31'd0, busy}, 32'd1);
    rx = 1'b1;
    repeat (BIT_CLKS / 2) @(negedge clk);
    chk("wait_idle_busy", {31'd0, busy}, 32'd1);
    repeat (BIT_CLKS * 3 / 4) @(negedge clk);
    chk("wait_idle_released", {31'd0, busy}, 32'd0);
    chk("data_after_ferr", {24'd0, data_out}, 32'h0000_00AA);
    drive_bit(1'b1);

    // 6: reset during data bit 4 of 0x3C, then 0xA5
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(logic'(8'h3C >> i));
    rx = 1'b1;
    repeat (BIT_CLKS / 2) @(negedge clk);
    chk("midframe_busy", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("midrst_data_out", {24'd0, data_out}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b1;
    last_good = 8'h00;
    repeat (2) drive_bit(1'b1);
    chk("after_rst_busy", {31'd0, busy}, 32'd0);
    expect_byte(8'hA5);
    send_frame(8'hA5, 1'b1);
    drive_bit(1'b1);

    // 5: short glitch rejected, then 0x00 frame
    rx = 1'b0;
    repeat (12) @(negedge clk);
    rx = 1'b1;
    chk("glitch_busy_set", {31'd0, busy}, 32'd1);
    repeat (32) @(negedge clk);
    chk("glitch_busy_cleared", {31'd0, busy}, 32'd0);
    drive_bit(1'b1);
    expect_byte(8'h00);
    send_frame(8'h00, 1'b1);
    repeat (2) drive_bit(1'b1);

    chk("scoreboard_empty", q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
